// File: rtl/ft_mon_pkg.sv
// Shared types and defaults for the TMR error monitor: per-replica FSM state encoding,
// internal counter widths and the parameter defaults used by ft_err_monitor.
package ft_mon_pkg;

  localparam int unsigned CntWDefault   = 8;
  localparam int unsigned ThreshDefault = 4;
  localparam int unsigned WindowDefault = 16;
  localparam int unsigned TsWDefault    = 32;

  localparam int unsigned NumReplicas = 3;
  localparam int unsigned StateW      = 2;
  // Sized for the largest legal THRESH (15) and WINDOW (255).
  localparam int unsigned StrikeW     = 4;
  localparam int unsigned QuietW      = 8;

  typedef enum logic [StateW-1:0] {
    StOk      = 2'd0,
    StSuspect = 2'd1,
    StFaulty  = 2'd2
  } mon_state_e;

  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage

// File: rtl/ft_replica_tracker.sv
// Per-replica health tracker: saturating error counter plus OK/SUSPECT/FAULTY FSM with
// strike count and quiet-cycle timer.
module ft_replica_tracker
  import ft_mon_pkg::*;
#(
  parameter int unsigned CNT_W  = CntWDefault,
  parameter int unsigned THRESH = ThreshDefault,
  parameter int unsigned WINDOW = WindowDefault
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              valid_i,
  input  logic              strike_i,
  output logic [CNT_W-1:0]  err_cnt_o,
  output logic [StateW-1:0] state_o,
  output logic              to_faulty_o
);

  localparam logic [StrikeW-1:0] ThreshV = StrikeW'(THRESH);
  localparam logic [QuietW-1:0]  WindowV = QuietW'(WINDOW);
  localparam logic [CNT_W-1:0]   CntMax  = {CNT_W{1'b1}};

  mon_state_e         state_q;
  logic [StrikeW-1:0] strike_q;
  logic [QuietW-1:0]  quiet_q;
  logic [CNT_W-1:0]   err_cnt_q;

  logic [StrikeW-1:0] strike_inc;
  logic [QuietW-1:0]  quiet_inc;

  assign strike_inc = strike_q + StrikeW'(1);
  assign quiet_inc  = quiet_q + QuietW'(1);

  // Used by the top to raise a single irq pulse on the edge that enters FAULTY.
  assign to_faulty_o = valid_i & strike_i & (state_q == StSuspect) & (strike_inc == ThreshV);

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      state_q   <= StOk;
      strike_q  <= '0;
      quiet_q   <= '0;
      err_cnt_q <= '0;
    end else if (valid_i) begin
      if (strike_i && (err_cnt_q != CntMax)) begin
        err_cnt_q <= err_cnt_q + CNT_W'(1);
      end
      case (state_q)
        StOk: begin
          if (strike_i) begin
            state_q  <= StSuspect;
            strike_q <= StrikeW'(1);
            quiet_q  <= '0;
          end
        end
        StSuspect: begin
          if (strike_i) begin
            strike_q <= strike_inc;
            quiet_q  <= '0;
            if (strike_inc == ThreshV) begin
              state_q <= StFaulty;
            end
          end else if (quiet_inc == WindowV) begin
            state_q  <= StOk;
            strike_q <= '0;
            quiet_q  <= '0;
          end else begin
            quiet_q <= quiet_inc;
          end
        end
        StFaulty: begin
          state_q <= StFaulty;
        end
        default: begin
          state_q  <= StOk;
          strike_q <= '0;
          quiet_q  <= '0;
        end
      endcase
    end
  end

  assign err_cnt_o = err_cnt_q;
  assign state_o   = state_q;

endmodule

// File: rtl/ft_err_monitor.sv
// TMR voter error monitor: classifies voter flags, tracks three replicas and raises alarm/irq.
// Optional FT_MON_TIMESTAMP_EN adds a free-running cycle counter and first-uncorrectable ts_o.
module ft_err_monitor
  import ft_mon_pkg::*;
#(
  parameter int unsigned CNT_W  = CntWDefault,
  parameter int unsigned THRESH = ThreshDefault,
  parameter int unsigned WINDOW = WindowDefault,
  parameter int unsigned TS_W   = TsWDefault
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_i,
  input  logic [2:0]             err_detected_i,
  input  logic                   err_corrected_i,
  input  logic                   err_any_i,
  input  logic                   clr_i,
  output logic [3*CNT_W-1:0]     err_cnt_o,
  output logic [CNT_W-1:0]       unc_cnt_o,
  output logic [3*StateW-1:0]    state_o,
  output logic [2:0]             faulty_o,
  output logic                   alarm_o,
  output logic                   irq_o
`ifdef FT_MON_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]        ts_o
`endif
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [1:0]       n_det;
  logic             unc_evt;
  logic             corr_evt;
  logic [2:0]       strikes;
  logic [2:0]       to_faulty;
  logic [CNT_W-1:0] unc_cnt_q;
  logic             irq_q;

  assign n_det    = popcount3(err_detected_i);
  assign unc_evt  = err_any_i & (~err_corrected_i | (n_det > 2'd1));
  assign corr_evt = err_corrected_i & (n_det == 2'd1);
  assign strikes  = corr_evt ? err_detected_i : 3'b000;

  for (genvar g = 0; g < NumReplicas; g++) begin : g_replica
    ft_replica_tracker #(
      .CNT_W  (CNT_W),
      .THRESH (THRESH),
      .WINDOW (WINDOW)
    ) u_tracker (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .clr_i       (clr_i),
      .valid_i     (valid_i),
      .strike_i    (strikes[g]),
      .err_cnt_o   (err_cnt_o[g*CNT_W +: CNT_W]),
      .state_o     (state_o[g*StateW +: StateW]),
      .to_faulty_o (to_faulty[g])
    );
    assign faulty_o[g] = (state_o[g*StateW +: StateW] == StFaulty);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      unc_cnt_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      if (valid_i && unc_evt && (unc_cnt_q != CntMax)) begin
        unc_cnt_q <= unc_cnt_q + CNT_W'(1);
      end
      irq_q <= valid_i & (unc_evt | (|to_faulty));
    end
  end

  assign unc_cnt_o = unc_cnt_q;
  assign irq_o     = irq_q;
  assign alarm_o   = (|faulty_o) | (|unc_cnt_q);

`ifdef FT_MON_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt_q;
  logic [TS_W-1:0] ts_q;
  logic            ts_valid_q;

  // The cycle counter only resets on rst_i; clr_i re-arms the first-event capture.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ts_cnt_q <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + TS_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      ts_q       <= '0;
      ts_valid_q <= 1'b0;
    end else if (valid_i && unc_evt && !ts_valid_q) begin
      ts_q       <= ts_cnt_q;
      ts_valid_q <= 1'b1;
    end
  end

  assign ts_o = ts_q;
`else
  logic unused_ts_w;
  assign unused_ts_w = (TS_W != 0);
`endif

endmodule

// File: tb/tb_ft_err_monitor.sv
// Directed self-checking bench for ft_err_monitor (default parameters).
module tb_ft_err_monitor;

  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid = 1'b0;
  logic [2:0]    det = 3'b000;
  logic          corr = 1'b0;
  logic          any = 1'b0;
  logic          clr = 1'b0;
  logic [3*CW-1:0] err_cnt;
  logic [CW-1:0] unc_cnt;
  logic [5:0]    state;
  logic [2:0]    faulty;
  logic          alarm;
  logic          irq;
`ifdef FT_MON_TIMESTAMP_EN
  logic [31:0]   ts;
  int unsigned   cyc = 0;
  logic [31:0]   exp_ts;
`endif

  int checks = 0;
  int failures = 0;
  int irq_seen = 0;
  int irq_base = 0;

  always #5 clk = ~clk;

`ifdef FT_MON_TIMESTAMP_EN
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else cyc <= cyc + 1;
  end
`endif

  ft_err_monitor dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .valid_i         (valid),
    .err_detected_i  (det),
    .err_corrected_i (corr),
    .err_any_i       (any),
    .clr_i           (clr),
    .err_cnt_o       (err_cnt),
    .unc_cnt_o       (unc_cnt),
    .state_o         (state),
    .faulty_o        (faulty),
    .alarm_o         (alarm),
    .irq_o           (irq)
`ifdef FT_MON_TIMESTAMP_EN
    ,
    .ts_o            (ts)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, sample 1 time unit after the following posedge.
  task automatic step(input logic v, input logic [2:0] d, input logic c, input logic a,
                      input logic cl, input logic r);
    @(negedge clk);
    rst = r; valid = v; det = d; corr = c; any = a; clr = cl;
    @(posedge clk);
    #1;
    if (irq === 1'b1) irq_seen++;
  endtask

  initial begin
    // Reset
    step(0, 3'b000, 0, 0, 0, 1);
    step(0, 3'b000, 0, 0, 0, 1);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    chk("rst_unc_cnt", 32'(unc_cnt), 0);
    chk("rst_state", 32'(state), 0);
    chk("rst_faulty", 32'(faulty), 0);
    chk("rst_alarm", 32'(alarm), 0);
    chk("rst_irq", 32'(irq), 0);

    // Invalid cycle carrying a strike must be ignored
    step(0, 3'b010, 1, 1, 0, 0);
    chk("inv_err_cnt1", 32'(err_cnt[CW +: CW]), 0);
    chk("inv_state1", 32'(state[3:2]), 0);

    // Four strikes on replica 1
    irq_seen = 0;
    step(1, 3'b010, 1, 1, 0, 0);
    chk("s1_state1", 32'(state[3:2]), 1);
    chk("s1_err_cnt1", 32'(err_cnt[CW +: CW]), 1);
    chk("s1_irq", 32'(irq), 0);
    step(1, 3'b010, 1, 1, 0, 0);
    step(1, 3'b010, 1, 1, 0, 0);
    chk("s3_state1", 32'(state[3:2]), 1);
    step(1, 3'b010, 1, 1, 0, 0);
    chk("s4_state1", 32'(state[3:2]), 2);
    chk("s4_irq", 32'(irq), 1);
    chk("s4_err_cnt1", 32'(err_cnt[CW +: CW]), 4);
    chk("s4_faulty", 32'(faulty), 32'h2);
    chk("s4_alarm", 32'(alarm), 1);
    step(0, 3'b000, 0, 0, 0, 0);
    chk("s4_irq_drop", 32'(irq), 0);
    chk("s4_irq_count", 32'(irq_seen), 1);
    chk("s4_sticky", 32'(state[3:2]), 2);

    // clr returns everything to idle
    step(0, 3'b000, 0, 0, 1, 0);
    chk("clr_err_cnt", 32'(err_cnt), 0);
    chk("clr_state", 32'(state), 0);
    chk("clr_alarm", 32'(alarm), 0);

    // One strike on replica 0, then WINDOW clean cycles
    irq_seen = 0;
    step(1, 3'b001, 1, 1, 0, 0);
    chk("q_suspect", 32'(state[1:0]), 1);
    repeat (15) step(1, 3'b000, 0, 0, 0, 0);
    chk("q_15_still_suspect", 32'(state[1:0]), 1);
    step(1, 3'b000, 0, 0, 0, 0);
    chk("q_16_ok", 32'(state[1:0]), 0);
    chk("q_err_cnt0", 32'(err_cnt[0 +: CW]), 1);
    chk("q_no_irq", 32'(irq_seen), 0);

    // Uncorrectable: two replicas disagree (err_corrected_i set but not single-bit)
    step(0, 3'b000, 0, 0, 1, 0);
    irq_seen = 0;
    step(1, 3'b011, 1, 1, 0, 0);
`ifdef FT_MON_TIMESTAMP_EN
    exp_ts = 32'(cyc - 1);
    chk("unc_ts", ts, exp_ts);
`endif
    chk("unc_cnt1", 32'(unc_cnt), 1);
    chk("unc_no_strike", 32'(err_cnt), 0);
    chk("unc_state", 32'(state), 0);
    chk("unc_irq", 32'(irq), 1);
    chk("unc_alarm", 32'(alarm), 1);
    step(1, 3'b000, 0, 1, 0, 0);
    chk("unc_cnt2", 32'(unc_cnt), 2);
`ifdef FT_MON_TIMESTAMP_EN
    chk("unc_ts_hold", ts, exp_ts);
`endif
    step(0, 3'b000, 0, 0, 0, 0);
    chk("unc_irq_drop", 32'(irq), 0);
    chk("unc_irq_count", 32'(irq_seen), 2);

    // Saturation on replica 2
    step(0, 3'b000, 0, 0, 1, 0);
    irq_seen = 0;
    repeat (255) step(1, 3'b100, 1, 1, 0, 0);
    chk("sat_255", 32'(err_cnt[2*CW +: CW]), 255);
    repeat (45) step(1, 3'b100, 1, 1, 0, 0);
    chk("sat_300", 32'(err_cnt[2*CW +: CW]), 255);
    chk("sat_state2", 32'(state[5:4]), 2);
    chk("sat_irq_count", 32'(irq_seen), 1);
    chk("sat_others", 32'(err_cnt[0 +: 2*CW]), 0);

    // clr coincident with a strike drops the strike
    irq_base = irq_seen;
    step(1, 3'b100, 1, 1, 1, 0);
    chk("clrs_err_cnt", 32'(err_cnt), 0);
    chk("clrs_state", 32'(state), 0);
    chk("clrs_unc", 32'(unc_cnt), 0);
    chk("clrs_irq", 32'(irq), 0);

    // Reset mid-SUSPECT discards progress
    step(1, 3'b001, 1, 1, 0, 0);
    chk("pre_rst_suspect", 32'(state[1:0]), 1);
    step(1, 3'b001, 1, 1, 1, 1);
    chk("mrst_err_cnt", 32'(err_cnt), 0);
    chk("mrst_state", 32'(state), 0);
    chk("mrst_unc", 32'(unc_cnt), 0);
    chk("mrst_faulty", 32'(faulty), 0);
    chk("mrst_alarm", 32'(alarm), 0);
    chk("mrst_irq", 32'(irq), 0);
    step(1, 3'b001, 1, 1, 0, 0);
    step(1, 3'b001, 1, 1, 0, 0);
    step(1, 3'b001, 1, 1, 0, 0);
    chk("post_rst_3_suspect", 32'(state[1:0]), 1);
    step(1, 3'b001, 1, 1, 0, 0);
    chk("post_rst_4_faulty", 32'(state[1:0]), 2);
    chk("post_rst_err_cnt0", 32'(err_cnt[0 +: CW]), 4);
    chk("post_rst_irq", 32'(irq_seen - irq_base), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
